// File: rtl/operand_pair_packer.sv
// Packs pairs of upstream half-words into {high, low} words and queues them in a small FIFO.
// Optional per-entry even parity on the output word is enabled with PACKER_PARITY_EN.
module operand_pair_packer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH/2-1:0]           in_data,
  output logic                         in_ready,
  input  logic                         in_flush,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         drop,
  output logic                         out_par,
  output logic [0:0]                   fsm_state
);

  localparam int HW = WIDTH / 2;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [0:0] WAIT_LO = 1'b0;
  localparam logic [0:0] WAIT_HI = 1'b1;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("operand_pair_packer: WIDTH must be even and >= 4");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("operand_pair_packer: DEPTH must be a power of 2 and >= 2");
  end

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [HW-1:0]    lo_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             accept;
  logic             load_lo;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_word;

  // Handshake semantics: a transfer happens on a falling clock edge where valid and
  // ready are both high; ready never depends on the same-cycle valid of either side.
  assign full      = (level == LW'(DEPTH));
  assign in_ready  = rst & ((state == WAIT_LO) | ~full);
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];
  assign fsm_state = state;

  // A flush masks the accept entirely, so neither the low register nor the FIFO moves.
  assign accept    = in_valid & in_ready & ~in_flush;
  assign load_lo   = accept & (state == WAIT_LO);
  assign push      = accept & (state == WAIT_HI);
  assign pop       = out_valid & out_ready;
  assign push_word = {in_data, lo_q};

  always_comb begin
    state_next = state;
    if (in_flush) begin
      state_next = WAIT_LO;
    end else if (load_lo) begin
      state_next = WAIT_HI;
    end else if (push) begin
      state_next = WAIT_LO;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      state  <= WAIT_LO;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      drop   <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= in_flush & (state == WAIT_HI);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Data storage carries no reset; validity is tracked by level alone.
  always_ff @(negedge clk) begin
    if (load_lo) begin
      lo_q <= in_data;
    end
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

`ifdef PACKER_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(negedge clk) begin
    if (push) begin
      par_mem[wr_ptr] <= ^push_word;
    end
  end

  // Gated by out_valid so the flag reads 0 out of reset and while empty.
  assign out_par = out_valid & par_mem[rd_ptr];
`else
  assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_operand_pair_packer.sv
// Randomized and directed bench for operand_pair_packer against a queue-based pairing model.
// Inputs change just after the rising edge; outputs are sampled 1 time unit after the falling edge.
module tb_operand_pair_packer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int HW    = WIDTH / 2;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [HW-1:0]    in_data = '0;
  logic             in_flush = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;
  logic             drop;
  logic             out_par;
  logic [0:0]       fsm_state;

  operand_pair_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .in_flush  (in_flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .drop      (drop),
    .out_par   (out_par),
    .fsm_state (fsm_state)
  );

  // Clock: rising edges at 5,15,...; the design acts on falling edges at 10,20,...
  always #5 clk = ~clk;

  // Reference model: words waiting downstream, plus an optional pending low half.
  logic [WIDTH-1:0] exp_q[$];
  logic             have_lo = 1'b0;
  logic [HW-1:0]    lo_val  = '0;
  logic             exp_drop = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic r);
    return r && (!have_lo || exp_q.size() < DEPTH);
  endfunction

  function automatic logic model_par();
`ifdef PACKER_PARITY_EN
    return (exp_q.size() != 0) ? ^exp_q[0] : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    check("level", level, exp_q.size());
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
    check("drop", drop, exp_drop);
    check("out_par", out_par, model_par());
    check("fsm_state", fsm_state, have_lo);
  endtask

  // One clock cycle: drive inputs, check in_ready, let the falling edge act, update model, compare.
  task automatic step(input logic r, input logic v, input logic [HW-1:0] d,
                      input logic f, input logic ordy);
    logic rdy;
    logic acc;
    logic pop;
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_data = d; in_flush = f; out_ready = ordy;
    #1;
    rdy = model_ready(r);
    check("in_ready", in_ready, rdy);
    @(negedge clk);
    #1;
    if (!r) begin
      exp_q.delete();
      have_lo  = 1'b0;
      exp_drop = 1'b0;
    end else begin
      acc      = v && rdy;
      pop      = ordy && (exp_q.size() != 0);
      exp_drop = f && have_lo;
      if (pop) void'(exp_q.pop_front());
      if (f) begin
        have_lo = 1'b0;
      end else if (acc) begin
        if (have_lo) begin
          exp_q.push_back({d, lo_val});
          have_lo = 1'b0;
        end else begin
          lo_val  = d;
          have_lo = 1'b1;
        end
      end
    end
    check_outputs();
  endtask

  task automatic push_half(input logic [HW-1:0] d, input logic ordy);
    step(1'b1, 1'b1, d, 1'b0, ordy);
  endtask

  task automatic idle(input logic ordy);
    step(1'b1, 1'b0, '0, 1'b0, ordy);
  endtask

  initial begin
    logic [HW-1:0] pend;

    // Reset state
    step(1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("reset_level", level, 0);
    check("reset_out_valid", out_valid, 1'b0);

    // Basic pair: one-edge latency
    push_half(16'h1234, 1'b1);
    check("pair_no_valid_after_low", out_valid, 1'b0);
    push_half(16'hABCD, 1'b1);
    check("pair_word", out_data, 32'hABCD1234);
    check("pair_level", level, 1);
    idle(1'b1);
    check("pair_drained", level, 0);

    // Fill with out_ready low: 2*DEPTH+1 halves
    for (int i = 0; i < 2 * DEPTH + 1; i++) push_half(HW'($urandom_range(0, 65535)), 1'b0);
    check("full_level", level, DEPTH);
    pend = HW'($urandom_range(0, 65535));
    push_half(pend, 1'b0);
    check("full_in_ready", in_ready, 1'b0);

    // Pop at full with high half pending: space appears only a cycle later
    push_half(pend, 1'b1);
    check("pop_at_full_level", level, DEPTH - 1);
    push_half(pend, 1'b0);
    check("refill_level", level, DEPTH);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    check("drain_level", level, 0);

    // Flush while holding a low half, with a same-cycle valid
    push_half(16'h0F0F, 1'b0);
    step(1'b1, 1'b1, 16'hF0F0, 1'b1, 1'b0);
    check("flush_drop", drop, 1'b1);
    check("flush_state", fsm_state, 1'b0);
    idle(1'b0);
    check("flush_drop_clear", drop, 1'b0);
    // Flush in WAIT_LO beats a same-cycle accept
    step(1'b1, 1'b1, 16'h7777, 1'b1, 1'b0);
    check("flush_lo_drop", drop, 1'b0);
    check("flush_lo_state", fsm_state, 1'b0);

    // Reset at level 3 while holding a low half
    for (int i = 0; i < 7; i++) push_half(HW'($urandom_range(0, 65535)), 1'b0);
    check("pre_reset_level", level, 3);
    step(1'b0, 1'b1, 16'h1111, 1'b0, 1'b1);
    check("mid_reset_level", level, 0);
    check("mid_reset_valid", out_valid, 1'b0);
    step(1'b0, 1'b1, 16'h2222, 1'b0, 1'b1);
    idle(1'b0);

    // Parity word 0x00000001
    push_half(16'h0001, 1'b0);
    push_half(16'h0000, 1'b0);
    check("par_word", out_data, 32'h00000001);
`ifdef PACKER_PARITY_EN
    check("par_one", out_par, 1'b1);
`else
    check("par_tied", out_par, 1'b0);
`endif
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) != 0),
           HW'($urandom_range(0, 65535)),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_pair_packer.md
OPERAND_PAIR_PACKER -- requirements
Module: operand_pair_packer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning packed output word width; it must be even and ≥ 4.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning pair-FIFO entries; it must be a power of 2 and ≥ 2.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on the falling edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream half-word valid.
REQ-006 The block SHALL have port in_data, input, WIDTH/2 bits: upstream half-word.
REQ-007 The block SHALL have port in_ready, output, 1 bit: half-word accepted when in_valid and in_ready are both high at an edge.
REQ-008 The block SHALL have port in_flush, input, 1 bit: discard any held low half.
REQ-009 The block SHALL have port out_valid, output, 1 bit: packed word available.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: packed word {high half, low half}, driving an adder-stage data_in.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts when out_valid and out_ready are both high at an edge.
REQ-012 The block SHALL have port level, output, clog2(DEPTH+1) bits: FIFO occupancy.
REQ-013 The block SHALL have port drop, output, 1 bit: one-cycle pulse when a held low half is discarded.
REQ-014 The block SHALL have port out_par, output, 1 bit: even parity of out_data (see Configuration).

Function
REQ-015 The FSM SHALL have two states: WAIT_LO (no half held) and WAIT_HI (low half held in a register).
REQ-016 In WAIT_LO, an accept SHALL store in_data as the low half and go to WAIT_HI.
REQ-017 In WAIT_HI, an accept SHALL push {in_data, held low} into the FIFO and go to WAIT_LO, on the same edge.
REQ-018 in_ready SHALL be registered-state-only: high in WAIT_LO; in WAIT_HI, high only when level < DEPTH; no combinational path from out_ready.
REQ-019 out_valid SHALL equal (level != 0), and out_data SHALL be the FIFO head taken directly from storage (registered).
REQ-020 Latency SHALL be 1 edge: out_valid rises on the edge that accepts the high half when the FIFO was empty.
REQ-021 Simultaneous push and pop SHALL leave level unchanged and preserve order; a pop at level==DEPTH frees space only from the next cycle.
REQ-022 FIFO read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow.
REQ-023 in_flush in WAIT_HI SHALL return the FSM to WAIT_LO, ignore any same-cycle accept, and pulse drop for 1 cycle.
REQ-024 in_flush in WAIT_LO SHALL take priority over a same-cycle accept: nothing is stored and drop stays 0.
REQ-025 in_flush SHALL NOT affect FIFO contents.
REQ-026 out_data SHALL hold its value while out_valid=1 and out_ready=0.

Reset
REQ-027 While rst=0 at a falling edge, the block SHALL set: FSM=WAIT_LO, pointers=0, level=0, out_valid=0, drop=0, out_par=0.
REQ-028 Reset mid-operation SHALL discard the held half and all FIFO entries with no drop pulse.
REQ-029 While rst=0, in_ready SHALL be 0; out_data SHALL be don't-care while out_valid=0.

Configuration
REQ-030 Macro PACKER_PARITY_EN defined: out_par SHALL be the registered XOR-reduce of each pushed word, stored per entry and presented alongside out_data.
REQ-031 Macro PACKER_PARITY_EN undefined: out_par SHALL be tied 0 and no parity storage SHALL exist.

Verification
REQ-032 Reset, then push 16'h1234 and 16'hABCD with out_ready=1 -> out_valid=1 one edge later, out_data=32'hABCD1234, level=1, then 0.
REQ-033 out_ready=0, push 2*DEPTH+1 halves -> level=4, in_ready=0 in WAIT_HI, no data lost; drain -> 4 words in order.
REQ-034 Level=4, assert out_ready with high half pending -> pop occurs, push occurs next edge, level returns to 4.
REQ-035 Low half held, in_flush=1 with in_valid=1 -> drop=1 for one cycle, FSM=WAIT_LO, level unchanged.
REQ-036 rst=0 at level=3 in WAIT_HI -> next cycle out_valid=0, level=0, in_ready=0 until rst=1.
REQ-037 With PACKER_PARITY_EN defined, push pair producing 32'h00000001 -> out_par=1; undefined -> out_par=0.
